regfile_read_arbiter: RTL and testbench

Round-robin arbiter that shares one register-file read port (the 32:1 read mux) among `N_REQ` requesters such as decode, the store-data path and the debug reader. Each cycle it grants at most one valid request, drives the granted 5-bit register address to the read mux, and returns the read data, tagged with the requester index, one cycle later. Register X31 (XZR) always reads as zero.

---
 rtl/regfile_read_arbiter_if.sv | 26 ++
 rtl/regfile_read_arbiter.sv | 71 +++++++
 tb/tb_regfile_read_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_read_arbiter_if.sv
// Request/response bundle between requesters, the register-file read mux and the arbiter.
// The arbiter sits on the slave side; requesters and the read mux drive the master side.
interface regfile_read_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int size  = 64,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*5-1:0] req_addr;
    logic [N_REQ-1:0]   req_ready;
    logic [4:0]         rf_ra;
    logic [size-1:0]    rf_rd;
    logic               rsp_valid;
    logic [ID_W-1:0]    rsp_id;
    logic [size-1:0]    rsp_data;

    modport master (
        output req_valid, req_addr, rf_rd,
        input  req_ready, rf_ra, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, rf_rd,
        output req_ready, rf_ra, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among N_REQ requesters.
// Grants at most one request per cycle and returns tagged read data one cycle later.
module regfile_read_arbiter #(
    parameter int N_REQ = 4,
    parameter int size  = 64,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                reset,
    regfile_read_arbiter_if.slave bus,
    output logic [7:0]          busy_cnt
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_next;
    logic [ID_W-1:0] win;
    logic            grant;
    logic            contended;
    logic [size-1:0] rd_value;

    // Search starts at ptr and wraps; reset suppresses any grant so nothing is consumed.
    always_comb begin
        grant = 1'b0;
        win   = '0;
        if (!reset) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!grant && bus.req_valid[(int'(ptr) + k) % N_REQ]) begin
                    grant = 1'b1;
                    win   = ID_W'((int'(ptr) + k) % N_REQ);
                end
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rf_ra     = '0;
        if (grant) begin
            bus.req_ready[win] = 1'b1;
            bus.rf_ra          = bus.req_addr[win*5 +: 5];
        end
    end

    always_comb begin
        ptr_next  = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
        contended = ($countones(bus.req_valid) > 1);
        rd_value  = (bus.rf_ra == 5'd31) ? '0 : bus.rf_rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr           <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_data  <= '0;
            busy_cnt      <= '0;
        end else begin
            bus.rsp_valid <= grant;
            if (grant) begin
                ptr          <= ptr_next;
                bus.rsp_id   <= win;
                bus.rsp_data <= rd_value;
            end
            // Saturating count of cycles where some requester had to wait.
            if (contended && busy_cnt != 8'hFF) begin
                busy_cnt <= busy_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Scoreboard bench for regfile_read_arbiter: a small arbiter model predicts grants and
// queues expected responses; a monitor pops and compares them when rsp_valid is due.
module tb_regfile_read_arbiter;

    localparam int N_REQ = 4;
    localparam int SIZE  = 64;
    localparam int ID_W  = 2;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [SIZE-1:0] data;
    } rsp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] busy_cnt;

    regfile_read_arbiter_if #(.N_REQ(N_REQ), .size(SIZE), .ID_W(ID_W)) bus ();

    regfile_read_arbiter #(.N_REQ(N_REQ), .size(SIZE), .ID_W(ID_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    logic [SIZE-1:0] regs [32];
    assign bus.rf_rd = regs[bus.rf_ra];

    int   checks = 0;
    int   errors = 0;
    int   model_ptr = 0;
    int   model_busy = 0;
    rsp_t exp_q[$];
    rsp_t mon_e;

    // Every response due this cycle is popped and compared; anything unexpected is flagged.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (bus.rsp_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL sb_rsp_valid: got %b expected 1", bus.rsp_valid);
            end else begin
                checks++;
                if (bus.rsp_id !== mon_e.id) begin
                    errors++;
                    $display("[TB] FAIL sb_rsp_id: got %0d expected %0d", bus.rsp_id, mon_e.id);
                end
                checks++;
                if (bus.rsp_data !== mon_e.data) begin
                    errors++;
                    $display("[TB] FAIL sb_rsp_data: got %h expected %h", bus.rsp_data, mon_e.data);
                end
            end
        end else begin
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected_rsp: got rsp_valid %b expected 0", bus.rsp_valid);
            end
        end
    end

    task automatic issue(input logic [3:0] v, input logic [19:0] a, output logic [3:0] exp_ready);
        int w;
        logic [4:0] ra;
        rsp_t e;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_addr  = a;
        #1;
        exp_ready = '0;
        w = -1;
        for (int k = 0; k < N_REQ; k++) begin
            if (w < 0 && v[(model_ptr + k) % N_REQ]) w = (model_ptr + k) % N_REQ;
        end
        if ($countones(v) > 1 && model_busy < 255) model_busy++;
        if (w >= 0) begin
            exp_ready[w] = 1'b1;
            ra = a[w*5 +: 5];
            e.id = w[ID_W-1:0];
            e.data = (ra == 5'd31) ? '0 : regs[ra];
            exp_q.push_back(e);
            model_ptr = (w + 1) % N_REQ;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        model_ptr = 0;
        model_busy = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = '1;
        bus.req_addr = {5'd3, 5'd2, 5'd1, 5'd4};
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (bus.req_ready !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL reset_req_ready: got %b expected 0000", bus.req_ready);
            end
            checks++;
            if (bus.rf_ra !== 5'd0) begin
                errors++;
                $display("[TB] FAIL reset_rf_ra: got %0d expected 0", bus.rf_ra);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        bus.req_valid = '0;
        model_ptr = 0;
        model_busy = 0;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_rsp: got valid %b id %0d data %h expected 0 0 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        checks++;
        if (busy_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_busy_cnt: got %0d expected 0", busy_cnt);
        end
    endtask

    task automatic test_single();
        logic [3:0] er;
        issue(4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, er);
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL single_ready: got %b expected 0100", bus.req_ready);
        end
        checks++;
        if (bus.rf_ra !== 5'd5) begin
            errors++;
            $display("[TB] FAIL single_rf_ra: got %0d expected 5", bus.rf_ra);
        end
        @(posedge clk);
        #2;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_data !== 64'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL single_rsp: got valid %b id %0d data %h expected 1 2 deadbeef",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        issue(4'b0000, '0, er);
    endtask

    task automatic test_round_robin();
        logic [3:0] er;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            issue(4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, er);
            checks++;
            if (bus.req_ready !== (4'b0001 << (k % 4))) begin
                errors++;
                $display("[TB] FAIL rr_grant_%0d: got %b expected %b", k, bus.req_ready,
                         4'b0001 << (k % 4));
            end
        end
        issue(4'b0000, '0, er);
        checks++;
        if (busy_cnt !== 8'd8) begin
            errors++;
            $display("[TB] FAIL rr_busy_cnt: got %0d expected 8", busy_cnt);
        end
    endtask

    task automatic test_pointer_rotation();
        logic [3:0] er;
        do_reset();
        issue(4'b1000, {5'd20, 5'd0, 5'd0, 5'd21}, er);
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL rot_first: got %b expected 1000", bus.req_ready);
        end
        issue(4'b1001, {5'd20, 5'd0, 5'd0, 5'd21}, er);
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL rot_wrap: got %b expected 0001", bus.req_ready);
        end
        issue(4'b1000, {5'd20, 5'd0, 5'd0, 5'd21}, er);
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL rot_next: got %b expected 1000", bus.req_ready);
        end
        issue(4'b0000, '0, er);
    endtask

    task automatic test_xzr();
        logic [3:0] er;
        issue(4'b0010, {5'd0, 5'd0, 5'd31, 5'd0}, er);
        checks++;
        if (bus.rf_ra !== 5'd31) begin
            errors++;
            $display("[TB] FAIL xzr_rf_ra: got %0d expected 31", bus.rf_ra);
        end
        @(posedge clk);
        #2;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== 64'd0) begin
            errors++;
            $display("[TB] FAIL xzr_rsp: got valid %b id %0d data %h expected 1 1 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        issue(4'b0000, '0, er);
    endtask

    task automatic test_reset_mid_grant();
        logic [3:0] er;
        @(negedge clk);
        bus.req_valid = 4'b0100;
        bus.req_addr = {5'd0, 5'd7, 5'd0, 5'd0};
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL midrst_grant: got %b expected 0100", bus.req_ready);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midrst_ready_forced: got %b expected 0000", bus.req_ready);
        end
        @(posedge clk);
        #2;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_rsp_dropped: got %b expected 0", bus.rsp_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.req_valid = '0;
        model_ptr = 0;
        model_busy = 0;
        issue(4'b0100, {5'd0, 5'd7, 5'd0, 5'd0}, er);
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL midrst_reissue: got %b expected 0100", bus.req_ready);
        end
        issue(4'b0000, '0, er);
    endtask

    task automatic test_saturation();
        logic [3:0] er;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            issue(4'b0011, {5'd0, 5'd0, 5'(k % 32), 5'd9}, er);
            checks++;
            if (bus.req_ready !== er) begin
                errors++;
                $display("[TB] FAIL sat_grant_%0d: got %b expected %b", k, bus.req_ready, er);
            end
        end
        issue(4'b0000, '0, er);
        checks++;
        if (busy_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL sat_busy_cnt: got %0d expected 255", busy_cnt);
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
        regs[5]  = 64'h0000_0000_DEAD_BEEF;
        regs[31] = '1;

        test_reset();
        test_single();
        test_round_robin();
        test_pointer_rotation();
        test_xzr();
        test_reset_mid_grant();
        test_saturation();

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
